// File: rtl/nibble_add_seq_if.sv
// Request/response handshake bundle for the nibble-serial add/subtract sequencer.
// The master side issues operands and consumes results; the slave side is the sequencer.
interface nibble_add_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, result, carry_out, overflow
    );
endinterface

// File: rtl/nibble_add_seq.sv
// Wide add/subtract done one nibble per clock on an external 4-bit adder,
// least significant nibble first, with the carry chained through c_r.
module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    nibble_add_seq_if.slave   bus,
    output logic [3:0]        add_a,
    output logic [3:0]        add_b,
    output logic              add_cin,
    input  logic [3:0]        add_sum,
    input  logic              add_cout
);
    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // RUN   | one nibble per cycle through the external adder, idx selects it
    // DONE  | result held with out_valid high until out_ready

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [NIBBLES-1:0][3:0] a_r;
    logic [NIBBLES-1:0][3:0] b_r;
    logic [NIBBLES-1:0][3:0] res_r;
    logic [IDX_W-1:0]        idx;
    logic                    c_r;
    logic                    carry_r;
    logic                    ovf_r;

    logic                    in_ready_c;
    logic                    out_valid_c;
    logic                    accept;
    logic                    last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        accept      = 1'b0;
        last        = 1'b0;
        add_a       = 4'h0;
        add_b       = 4'h0;
        add_cin     = 1'b0;
        case (state_q)
            IDLE: begin
                // Held low during reset so a requester never sees a phantom accept.
                in_ready_c = ~rst;
                accept     = bus.in_valid & in_ready_c;
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a   = a_r[idx];
                add_b   = b_r[idx];
                add_cin = c_r;
                last    = (idx == IDX_LAST);
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            idx     <= '0;
            c_r     <= 1'b0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_r     <= bus.op_a;
                        // Subtract is A + ~B + 1: invert B here, seed the carry with 1.
                        b_r     <= bus.sub ? ~bus.op_b : bus.op_b;
                        c_r     <= bus.sub;
                        idx     <= '0;
                        res_r   <= '0;
                        carry_r <= 1'b0;
                        ovf_r   <= 1'b0;
                    end
                end
                RUN: begin
                    res_r[idx] <= add_sum;
                    c_r        <= add_cout;
                    if (last) begin
                        carry_r <= add_cout;
                        ovf_r   <= (a_r[NIBBLES-1][3] == b_r[NIBBLES-1][3]) &
                                   (add_sum[3] != a_r[NIBBLES-1][3]);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.result    = res_r;
    assign bus.carry_out = carry_r;
    assign bus.overflow  = ovf_r;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed plus random checks of nibble_add_seq against a plain-arithmetic reference,
// with the external 4-bit adder modelled here.
module tb_nibble_add_seq;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] add_a, add_b, add_sum;
    logic       add_cin, add_cout;
    logic [4:0] adder_full;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;

    nibble_add_seq_if #(.NIBBLES(NIB)) bus ();

    nibble_add_seq #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    assign add_sum    = adder_full[3:0];
    assign add_cout   = adder_full[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {carry, overflow, result} from unsigned/signed arithmetic on the whole operands.
    function automatic logic [W+1:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
        longint sa, sb, sr;
        logic [W:0] u;
        logic [W-1:0] r;
        logic c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sb;
        end else begin
            u  = {1'b0, a} + {1'b0, b};
            r  = u[W-1:0];
            c  = u[W];
            sr = sa + sb;
        end
        v = (sr > 32767) || (sr < -32768);
        return {c, v, r};
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input string tag, input int hold, input bit busy);
        logic [W+1:0] e;
        int lat;
        bit got;
        e = ref_calc(a, b, s);
        @(negedge clk);
        bus.op_a = a; bus.op_b = b; bus.sub = s; bus.in_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (bus.in_ready === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_accept"}, 32'(got), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            if (lat < NIB) check({tag, "_add_a"}, 32'(add_a), 32'((a >> (4 * lat)) & 16'hF));
            if (lat == 0) check({tag, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
            if (busy && lat == 1) begin
                bus.in_valid = 1'b1;
                bus.op_a = W'($urandom); bus.op_b = W'($urandom); bus.sub = 1'b1;
            end
            if (busy && lat == 2) bus.in_valid = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(NIB));
        check({tag, "_result"}, 32'(bus.result), 32'(e[W-1:0]));
        check({tag, "_carry"}, 32'(bus.carry_out), 32'(e[W+1]));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(e[W]));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, "_hold_res"}, {bus.carry_out, bus.overflow, bus.result}, 32'(e));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_drain_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [W+1:0] e;
        logic [W+1:0] exp_q[$];
        logic [W-1:0] ra, rb;
        logic rs;
        int acc_t[3];
        int nacc, nres;
        bit pend;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.sub = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags", {bus.carry_out, bus.overflow}, 32'd0);
        check("rst_adder", {add_a, add_b, add_cin}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 32'(bus.in_ready), 32'd1);

        run_op(16'h1234, 16'h4321, 1'b0, "plain_add", 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, "ucarry", 0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, "sovf_add", 0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, "sub_borrow", 0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, "sub_ovf", 0, 1'b0);
        run_op(16'hA5C3, 16'h3C5A, 1'b1, "backpressure", 5, 1'b1);

        for (int i = 0; i < 6; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "random", i % 2, 1'b0);

        // Back-to-back: in_valid and out_ready held high across three requests.
        nacc = 0; nres = 0; pend = 1'b0;
        @(negedge clk);
        bus.op_a = W'($urandom); bus.op_b = W'($urandom); bus.sub = 1'($urandom_range(0, 1));
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int c = 0; c < 80 && nres < 3; c++) begin
            if (pend) begin
                pend = 1'b0;
                if (nacc < 3) begin
                    bus.op_a = W'($urandom); bus.op_b = W'($urandom);
                    bus.sub = 1'($urandom_range(0, 1));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check("b2b_result", {bus.carry_out, bus.overflow, bus.result}, 32'(e));
                nres++;
            end
            if (bus.in_valid && bus.in_ready === 1'b1 && nacc < 3) begin
                acc_t[nacc] = cyc;
                exp_q.push_back(ref_calc(bus.op_a, bus.op_b, bus.sub));
                nacc++;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        check("b2b_results", 32'(nres), 32'd3);
        check("b2b_accepts", 32'(nacc), 32'd3);
        if (nacc == 3) begin
            check("b2b_space1", 32'(acc_t[1] - acc_t[0]), 32'(NIB + 2));
            check("b2b_space2", 32'(acc_t[2] - acc_t[1]), 32'(NIB + 2));
        end

        // Reset while idx = 2.
        @(negedge clk);
        ra = 16'h1111; rb = 16'h2222; rs = 1'b0;
        bus.op_a = ra; bus.op_b = rb; bus.sub = rs; bus.in_valid = 1'b1;
        check("mid_pre_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_idx2_add_a", 32'(add_a), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_result", 32'(bus.result), 32'd0);
        check("mid_rst_flags", {bus.carry_out, bus.overflow}, 32'd0);
        check("mid_rst_adder", {add_a, add_b, add_cin}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rel_ready", 32'(bus.in_ready), 32'd1);
        run_op(16'h0001, 16'h0001, 1'b0, "post_rst", 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Multi-cycle sequencer that performs wide add/subtract on the team's shared 4-bit ripple-carry adder. It processes one nibble per clock, least significant first, and chains the carry through a register. Operands and results cross valid/ready handshakes. The 4-bit adder sits outside this block and is wired to the `add_*` ports at the next level up.

## Interface
Parameters:
- `NIBBLES`, default 4: operand width in nibbles. W = 4*NIBBLES. Legal range 2..16.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request.
- `op_a`  in  W  operand A, unsigned or two's complement.
- `op_b`  in  W  operand B.
- `sub`  in  1  0 selects A+B; 1 selects A−B.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  W  sum or difference.
- `carry_out`  out  1  final adder carry. For subtract, 1 means no borrow.
- `overflow`  out  1  signed (two's complement) overflow.
- `add_a`  out  4  adder operand A nibble.
- `add_b`  out  4  adder operand B nibble.
- `add_cin`  out  1  adder carry in.
- `add_sum`  in  4  adder sum, combinational from `add_*`.
- `add_cout`  in  1  adder carry out.

## Operation
- State machine states: IDLE, RUN, DONE. Internal registers:
  - `a_r`, `b_r` (each W bits)
  - `idx` (index counter)
  - `c_r` (carry register)
  - `res_r` (result register)
- **IDLE.**
  - `in_ready` = 1.
  - On `in_valid & in_ready`:
    - `a_r` ← `op_a`
    - `b_r` ← `sub ? ~op_b : op_b`
    - `c_r` ← `sub`
    - `idx` ← 0
    - state → RUN
  - A new request clears `res_r`, `out_valid`, `carry_out` and `overflow` to 0.
- **RUN.**
  - Drive `add_a` = `a_r[4*idx +: 4]`, `add_b` = `b_r[4*idx +: 4]`, `add_cin` = `c_r`.
  - Each edge:
    - `res_r[4*idx +: 4]` ← `add_sum`
    - `c_r` ← `add_cout`
    - `idx` ← `idx`+1
  - On the edge where `idx` == NIBBLES−1, instead of incrementing:
    - state → DONE
    - `carry_out` ← `add_cout`
    - `overflow` ← (`a_r[W-1]` == `b_r[W-1]`) & (`add_sum[3]` != `a_r[W-1]`)
- **DONE.**
  - `out_valid` = 1.
  - `result`, `carry_out` and `overflow` are held stable until `out_ready`.
  - On `out_valid & out_ready`: state → IDLE.
- **Outside RUN:** `add_a`, `add_b` and `add_cin` are driven to 0.
- **`in_ready` outside IDLE:** `in_ready` = 0 in RUN and DONE. `in_valid` during those states is ignored; the requester must hold it.
- **Result port:** `result` shows `res_r` at all times. It is only meaningful while `out_valid` = 1.
- **Handshake outputs:** `in_ready` and `out_valid` are decoded from state only. They have no combinational path from `in_valid` or `out_ready`.
- **Arithmetic:** all arithmetic is modulo 2^W. `sub` = 1 computes A + ~B + 1.

## Timing
- **Reset:** `rst` high at an edge, from any state (including mid-RUN), forces:
  - state = IDLE
  - `idx`, `c_r`, `res_r`, `a_r`, `b_r` = 0
  - `out_valid` = 0, `carry_out` = 0, `overflow` = 0
  - `add_a`, `add_b`, `add_cin` = 0
  - `in_ready` is 0 while `rst` is high and 1 in the first cycle after.
- **Latency:** call the acceptance edge E.
  - Nibble i is computed in the cycle after edge E+i and captured at edge E+i+1.
  - `out_valid` rises after edge E+NIBBLES.
- **Throughput:** at most one operation per NIBBLES+2 cycles. This covers NIBBLES RUN cycles, one DONE cycle (with `out_ready` held high) and one IDLE cycle.
- **Backpressure:** with `out_ready` low, DONE holds indefinitely with outputs constant.
- **Adder path:** `add_sum` and `add_cout` are sampled at the edge ending each RUN cycle. The external adder must settle within one clock period.
- **`idx` range:** `idx` never exceeds NIBBLES−1. No wrap-around is visible outside the block.

## Test plan
All scenarios use NIBBLES=4; the external adder is modelled in the bench.
- **Plain add:** A=0x1234, B=0x4321, sub=0 → `result`=0x5555, `carry_out`=0, `overflow`=0. `out_valid` rises exactly 4 cycles after acceptance. The bench also checks the `add_a` nibble sequence 4, 3, 2, 1.
- **Unsigned carry:** 0xFFFF+0x0001 → 0x0000, `carry_out`=1, `overflow`=0. Also 0x7FFF+0x0001 → 0x8000, `carry_out`=0, `overflow`=1.
- **Subtract:**
  - 0x0005−0x0007 → 0xFFFE, `carry_out`=0 (borrow), `overflow`=0.
  - 0x8000−0x0001 → 0x7FFF, `carry_out`=1, `overflow`=1.
- **Backpressure and busy:**
  - Hold `out_ready`=0 for 5 cycles → `result` and flags stay constant, `in_ready`=0.
  - Pulse `in_valid` with new operands during RUN → request is ignored and the first result is unchanged.
- **Back-to-back:** keep `in_valid` and `out_ready` high for 3 requests → each result is correct, and accepts are spaced 6 cycles apart.
- **Mid-operation reset:** assert `rst` for 1 cycle at `idx`=2 → next cycle shows IDLE, `in_ready`=1, `out_valid`=0, all outputs 0. A subsequent 0x0001+0x0001 returns 0x0002.
